// File: rtl/calc_display.sv
// Signed 32-bit value to 8-digit multiplexed seven-segment display.
// A serial double-dabble converter updates the digit registers; a free-running scanner drives an/seg.
module calc_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BCD_W  = 40;
    localparam int unsigned BITS_W = 5;

    // Internal digit codes; 0..9 are decimal digits
    localparam logic [3:0] C_MINUS = 4'd10;
    localparam logic [3:0] C_E     = 4'd11;
    localparam logic [3:0] C_R     = 4'd12;
    localparam logic [3:0] C_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cap_q, cap_d;
    logic [31:0]         shown_q, shown_d;
    logic [31:0]         sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BITS_W-1:0]   bit_q, bit_d;
    logic [7:0][3:0]     dig_q, dig_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [BCD_W-1:0]    adj;
    logic                seen;
    logic                placed;

    function automatic logic [6:0] encode(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            C_MINUS: return 7'b0111111;
            C_E:     return 7'b0000110;
            C_R:     return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Conversion FSM: capture, 32 double-dabble steps, then commit to the digit registers
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        shown_d = shown_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        adj     = bcd_q;
        seen    = 1'b0;
        placed  = 1'b0;

        case (state_q)
            IDLE: begin
                if (value != shown_q) begin
                    cap_d   = value;
                    sh_d    = value[31] ? 32'(-value) : value;
                    bcd_d   = '0;
                    bit_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                for (int i = 0; i < 10; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                    end
                end
                bcd_d = {adj[BCD_W-2:0], sh_q[31]};
                sh_d  = {sh_q[30:0], 1'b0};
                bit_d = bit_q + BITS_W'(1);
                if (bit_q == BITS_W'(31)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                shown_d = cap_q;
                // Any non-zero digit from position 7 upward means more than 9999999
                if (bcd_q[BCD_W-1:28] != '0) begin
                    ovf_d = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        dig_d[i] = C_BLANK;
                    end
                    dig_d[2] = C_E;
                    dig_d[1] = C_R;
                    dig_d[0] = C_R;
                end else begin
                    ovf_d = 1'b0;
                    for (int i = 7; i >= 0; i--) begin
                        if (i == 0 || seen || bcd_q[4*i +: 4] != 4'd0) begin
                            dig_d[i] = bcd_q[4*i +: 4];
                            seen     = 1'b1;
                        end else begin
                            dig_d[i] = C_BLANK;
                        end
                    end
                    // Sign goes on the first blank position left of the number
                    if (cap_q[31]) begin
                        for (int i = 1; i < 8; i++) begin
                            if (!placed && dig_d[i] == C_BLANK) begin
                                dig_d[i] = C_MINUS;
                                placed   = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Scanner: next index and the registered anode/segment values aligned to it
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        an_d  = ~(8'b1 << idx_d);
        seg_d = encode(dig_d[idx_d]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            shown_q <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            dig_q   <= {{7{C_BLANK}}, 4'd0};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'b1111_1110;
            seg_q   <= 7'b1000000;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            shown_q <= shown_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: reset, conversion cases, scan order, mid-conversion changes and reset.
module tb_calc_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    calc_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .an    (an),
        .seg   (seg),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected segment pattern for a hand-written digit code (A '-', B 'E', C 'r', F blank)
    function automatic logic [6:0] exp_seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            4'hB: return 7'b0000110;
            4'hC: return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Record the segment pattern seen for each anode over one full scan
    task automatic capture(output logic [7:0][6:0] obs);
        obs = {8{7'h55}};
        repeat (32) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (an == ~(8'b1 << i)) obs[i] = seg;
            end
        end
    endtask

    // Wait (bounded) for busy to drop; returns number of busy samples seen
    task automatic wait_idle(output int nbusy);
        nbusy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            else if (nbusy > 0) break;
        end
    endtask

    task automatic test_reset();
        logic [7:0][6:0] obs;
        int nbusy;
        rst = 1'b1;
        value = 32'd0;
        @(posedge clk); #1;
        checks++; if (an !== 8'b1111_1110) begin errors++; $display("FAIL reset_an: got %b expected 11111110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk); rst = 1'b0;
        nbusy = 0;
        repeat (40) begin @(negedge clk); if (busy) nbusy++; end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL reset_no_convert: busy samples %0d expected 0", nbusy); end
        capture(obs);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp_seg((i == 0) ? 4'h0 : 4'hF)) begin
                errors++; $display("FAIL reset_digit%0d: got %b expected %b", i, obs[i], exp_seg((i == 0) ? 4'h0 : 4'hF));
            end
        end
    endtask

    task automatic test_conversion();
        logic [31:0] vals  [7] = '{32'd1234, -32'sd56, -32'sd9999999, 32'd10000000, 32'd7, 32'h8000_0000, 32'd0};
        logic [31:0] codes [7] = '{32'hFFFF_1234, 32'hFFFF_FA56, 32'hA999_9999, 32'hFFFF_FBCC, 32'hFFFF_FFF7, 32'hFFFF_FBCC, 32'hFFFF_FFF0};
        logic        ovfs  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0][6:0] obs;
        logic [31:0] code;
        int nbusy;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk); value = vals[t];
            wait_idle(nbusy);
            checks++;
            if (nbusy != 33) begin errors++; $display("FAIL conv%0d_busy_cycles: got %0d expected 33", t, nbusy); end
            checks++;
            if (ovf !== ovfs[t]) begin errors++; $display("FAIL conv%0d_ovf: got %b expected %b", t, ovf, ovfs[t]); end
            capture(obs);
            code = codes[t];
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs[i] !== exp_seg(code[4*i +: 4])) begin
                    errors++; $display("FAIL conv%0d_digit%0d: got %b expected %b", t, i, obs[i], exp_seg(code[4*i +: 4]));
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [31:0] code = 32'hA123_4567;
        logic [7:0] prev;
        logic [7:0] exp_an;
        int nbusy;
        int idx;
        bit synced = 1'b0;
        @(negedge clk); value = -32'sd1234567;
        wait_idle(nbusy);
        for (int k = 0; k < 40; k++) begin
            prev = an;
            @(negedge clk);
            if (prev == 8'b0111_1111 && an == 8'b1111_1110) begin synced = 1'b1; break; end
        end
        checks++;
        if (!synced) begin errors++; $display("FAIL scan_sync: got no 01111111->11111110 wrap expected one"); end
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) @(negedge clk);
            idx = (c / 4) % 8;
            exp_an = ~(8'b1 << idx);
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL scan_an_step%0d: got %b expected %b", c, an, exp_an); end
            checks++;
            if (seg !== exp_seg(code[4*idx +: 4])) begin
                errors++; $display("FAIL scan_seg_step%0d: got %b expected %b", c, seg, exp_seg(code[4*idx +: 4]));
            end
        end
    endtask

    task automatic test_midchange();
        logic [7:0][6:0] obs;
        int n;
        @(negedge clk); value = 32'd5;
        @(posedge clk); #1; n = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_start: got %b expected 1", busy); end
        while (cyc != n + 10) begin @(posedge clk); #1; end
        @(negedge clk); value = 32'd77;
        while (cyc != n + 32) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_n32: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_n33: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_restart_n34: got %b expected 1", busy); end
        capture(obs);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp_seg((i == 0) ? 4'h5 : 4'hF)) begin
                errors++; $display("FAIL mid_first_digit%0d: got %b expected %b", i, obs[i], exp_seg((i == 0) ? 4'h5 : 4'hF));
            end
        end
        while (cyc != n + 66) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_n66: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_n67: got %b expected 0", busy); end
        capture(obs);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp_seg((i < 2) ? 4'h7 : 4'hF)) begin
                errors++; $display("FAIL mid_final_digit%0d: got %b expected %b", i, obs[i], exp_seg((i < 2) ? 4'h7 : 4'hF));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0][6:0] obs;
        int nbusy;
        @(negedge clk); value = 32'd10000000;
        wait_idle(nbusy);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf: got %b expected 1", ovf); end
        @(negedge clk); value = 32'd999;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1; value = 32'd0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %b expected 0", ovf); end
        checks++; if (an !== 8'b1111_1110) begin errors++; $display("FAIL rmid_an: got %b expected 11111110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rmid_seg: got %b expected 1000000", seg); end
        @(negedge clk); rst = 1'b0;
        nbusy = 0;
        repeat (40) begin @(negedge clk); if (busy) nbusy++; end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL rmid_no_commit: busy samples %0d expected 0", nbusy); end
        capture(obs);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp_seg((i == 0) ? 4'h0 : 4'hF)) begin
                errors++; $display("FAIL rmid_digit%0d: got %b expected %b", i, obs[i], exp_seg((i == 0) ? 4'h0 : 4'hF));
            end
        end
    endtask

    task automatic test_reset_nonzero();
        logic [7:0][6:0] obs;
        int nbusy;
        @(negedge clk); rst = 1'b1; value = 32'd42;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnz_busy_first_edge: got %b expected 1", busy); end
        wait_idle(nbusy);
        capture(obs);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp_seg((i == 0) ? 4'h2 : (i == 1) ? 4'h4 : 4'hF)) begin
                errors++; $display("FAIL rnz_digit%0d: got %b expected %b", i, obs[i], exp_seg((i == 0) ? 4'h2 : (i == 1) ? 4'h4 : 4'hF));
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_scan();
        test_midchange();
        test_reset_mid();
        test_reset_nonzero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
